pipelined_mux_n_to_1: RTL
=========================

PIPELINED_MUX_N_TO_1 -- requirements
Module: pipelined_mux_n_to_1

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, bits per channel.
REQ-002 The block SHALL have parameter N, default 4, number of input channels (N >= 2).
REQ-003 The block SHALL have localparam SEL_W = clog2(N), select width.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port in_data, input, N*WIDTH bits: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 The block SHALL have port in_valid, input, N bits: per-channel valid.
REQ-008 The block SHALL have port in_ready, output, N bits: per-channel ready, at most one bit high.
REQ-009 The block SHALL have port mode, input, 1 bit: 0 = explicit select, 1 = round-robin.
REQ-010 The block SHALL have port sel, input, SEL_W bits: channel index used when mode = 0.
REQ-011 The block SHALL have port out_data, output, WIDTH bits: registered selected word.
REQ-012 The block SHALL have port out_sel, output, SEL_W bits: index of the channel that supplied out_data.
REQ-013 The block SHALL have port out_valid, output, 1 bit: out_data/out_sel are valid.
REQ-014 The block SHALL have port out_ready, input, 1 bit: downstream accepts.

Function
REQ-015 A transfer on channel i SHALL occur when in_valid[i] and in_ready[i] are high at a rising edge; the output transfer SHALL occur when out_valid and out_ready are high.
REQ-016 accept SHALL equal (!out_valid || out_ready); the output register SHALL load only when accept is high and a grant exists, which gives full throughput of one word per cycle.
REQ-017 In mode 0, the grant SHALL be sel when in_valid[sel] is high and sel < N; otherwise there SHALL be no grant.
REQ-018 In mode 1, the grant SHALL be the first channel with in_valid high, searching upward from (rr_ptr+1) mod N and wrapping to 0.
REQ-019 in_ready[g] SHALL be accept for the granted channel g; all other in_ready bits SHALL be 0, and all bits SHALL be 0 when there is no grant.
REQ-020 Latency SHALL be 1 cycle: a word accepted at edge k SHALL appear on out_data/out_sel with out_valid = 1 after edge k.
REQ-021 While out_valid = 1 and out_ready = 0, out_data, out_sel and out_valid SHALL hold unchanged regardless of in_*, sel or mode changes.
REQ-022 If accept is high and there is no grant, out_valid SHALL go to 0 at the next edge, and out_data/out_sel SHALL hold their last value.
REQ-023 rr_ptr SHALL update to g only on an input transfer in mode 1; it SHALL NOT change in mode 0 or on stalls.
REQ-024 A mode or sel change SHALL take effect on the very next grant evaluation with no drain cycle.
REQ-025 Simultaneous output drain and new load in the same cycle SHALL replace the held word with the new one, with no bubble.
REQ-026 Outputs SHALL be driven only from registers; in_ready SHALL be combinational from in_valid, mode, sel, rr_ptr, out_valid and out_ready.

Reset
REQ-027 When rst_n = 0 at a rising edge, out_valid SHALL become 0, out_data 0, out_sel 0 and rr_ptr N-1, so the first round-robin search starts at channel 0.
REQ-028 Reset mid-stall SHALL discard the held word; in_ready SHALL be all 0 during the reset cycle.

Structure
REQ-029 A shared package mux_pkg SHALL hold the defaults DEFAULT_WIDTH = 32 and DEFAULT_N = 4, plus the constants MODE_SEL = 0 and MODE_RR = 1.
REQ-030 Grant logic SHALL be one sub-module rr_arbiter (parameter N; ports req, ptr, mode, sel, grant_valid, grant_idx); the output register and rr_ptr SHALL stay in pipelined_mux_n_to_1.

Verification
REQ-031 Reset check: hold rst_n = 0 for 2 cycles with all in_valid = 1 -> out_valid = 0, out_data = 0, in_ready = 0000.
REQ-032 Mode 0 check: sel = 2, in_valid = 0100, ch2 = 0xDEADBEEF, out_ready = 1 -> next cycle out_data = 0xDEADBEEF, out_sel = 2; then sel = 1 with in_valid[1] = 0 -> out_valid = 0.
REQ-033 Round-robin check: mode = 1, in_valid = 1111 held, out_ready = 1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles.
REQ-034 Back-pressure check: out_ready = 0 for 3 cycles with a word held (out_sel = 1) and sel/mode toggling -> out_* stable and in_ready = 0000; out_ready = 1 -> drain and new load in the same cycle.
REQ-035 Sparse round-robin check: in_valid = 1010, rr_ptr = 1 -> grant 3, then 1, then 3; mid-stream rst_n = 0 -> next grant starts search at 0.
REQ-036 Parameter check: WIDTH = 8, N = 3, mode 0 with sel = 3 -> no grant, in_ready = 000, out_valid falls after drain.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared defaults and mode encodings for the pipelined N-to-1 mux.
package mux_pkg;
  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_N     = 4;
  localparam logic MODE_SEL    = 1'b0;
  localparam logic MODE_RR     = 1'b1;
endpackage

// File: rtl/rr_arbiter.sv
// Grant selection: explicit select or round-robin search starting after ptr.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  output logic             grant_valid,
  output logic [SEL_W-1:0] grant_idx
);
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (mode == MODE_SEL) begin
      // A select value >= N matches no channel, so it yields no grant.
      for (int i = 0; i < N; i++) begin
        if (int'(sel) == i && req[i]) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_W'(i);
        end
      end
    end else begin
      // Scan from farthest to nearest so the nearest requester after ptr wins.
      for (int k = N; k >= 1; k--) begin
        if (req[(int'(ptr) + k) % N]) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_W'((int'(ptr) + k) % N);
        end
      end
    end
  end
endmodule

// File: rtl/pipelined_mux_n_to_1.sv
// N-to-1 mux with a single registered output stage and ready/valid handshakes.
module pipelined_mux_n_to_1
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N     = DEFAULT_N,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_valid,
  input  logic               out_ready
);
  logic [WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0] osel_q, osel_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             vld_q, vld_d;
  logic             accept, gvalid;
  logic [SEL_W-1:0] gidx;
  logic [WIDTH-1:0] gdata;

  rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_arb (
    .req         (in_valid),
    .ptr         (rr_ptr_q),
    .mode        (mode),
    .sel         (sel),
    .grant_valid (gvalid),
    .grant_idx   (gidx)
  );

  assign accept = !vld_q || out_ready;

  always_comb begin
    in_ready = '0;
    gdata    = '0;
    for (int i = 0; i < N; i++) begin
      if (gidx == SEL_W'(i)) begin
        gdata = in_data[i*WIDTH +: WIDTH];
        // Suppressed while in reset so nothing is handshaken into a discarded slot.
        in_ready[i] = gvalid && accept && rst_n;
      end
    end
  end

  always_comb begin
    data_d   = data_q;
    osel_d   = osel_q;
    vld_d    = vld_q;
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      vld_d = gvalid;
      if (gvalid) begin
        data_d = gdata;
        osel_d = gidx;
        if (mode == MODE_RR) rr_ptr_d = gidx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q   <= '0;
      osel_q   <= '0;
      vld_q    <= 1'b0;
      rr_ptr_q <= SEL_W'(N - 1);
    end else begin
      data_q   <= data_d;
      osel_q   <= osel_d;
      vld_q    <= vld_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_sel   = osel_q;
  assign out_valid = vld_q;
endmodule
